// File: rtl/tinyrv1_dbg_pkg.sv
// ----------------------------------------------------------------------------
// tinyrv1_dbg_pkg
//
// Shared definitions for the TinyRV1 debug read-out blocks.
//   dump_state_t : state encoding of the register-file dump engine
//   RF_ADDR_W    : register index width of the TinyRV1 register file
//   RF_DATA_W    : register data width of the TinyRV1 register file
// ----------------------------------------------------------------------------
package tinyrv1_dbg_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage : tinyrv1_dbg_pkg

// File: rtl/regfile_dump.sv
// ----------------------------------------------------------------------------
// regfile_dump
//
// Debug read-out engine for the TinyRV1 register file. On an accepted start
// it walks the inclusive index range [lo_addr, hi_addr] over one spare
// regfile read port and streams {index, value} beats on a valid/ready link.
//
// Ports
//   clk       : clock
//   rst       : synchronous, active-high reset
//   start     : dump request, only looked at while idle
//   lo_addr   : first register index, captured with start
//   hi_addr   : last register index (inclusive), captured with start
//   abort     : cancel the dump in progress (no done pulse)
//   rf_raddr  : regfile read address, straight from the pointer register
//   rf_rdata  : combinational regfile read data for rf_raddr
//   out_val   : beat valid
//   out_rdy   : consumer ready
//   out_addr  : register index of the current beat
//   out_data  : register value of the current beat
//   busy      : engine is not idle
//   done      : one-cycle pulse when a dump completes normally
//
// Each value is sampled in the cycle its index sits on rf_raddr, so a beat
// reflects the register at read time (per-beat snapshot, not atomic).
// ----------------------------------------------------------------------------
module regfile_dump
   import tinyrv1_dbg_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] lo_addr,
   input  logic [ADDR_W-1:0] hi_addr,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              out_val,
   input  logic              out_rdy,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] hi_q, hi_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;
   logic              val_d;
   logic              hs;
   logic              last_beat;

   // The read address is the pointer register itself; the regfile answers
   // combinationally and the value is captured into the output stage.
   assign rf_raddr  = ptr_q;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE) && !abort;
   assign hs        = out_val && out_rdy;
   assign last_beat = (out_addr == hi_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hi_d    = hi_q;
      addr_d  = out_addr;
      data_d  = out_data;
      val_d   = out_val;

      if (state_q != IDLE && abort) begin
         // Abort outranks handshake and completion; the pending beat is dropped.
         state_d = IDLE;
         val_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // abort in IDLE also suppresses the start
               if (start && !abort) begin
                  ptr_d   = lo_addr;
                  hi_d    = hi_addr;
                  state_d = (lo_addr > hi_addr) ? DONE : LOAD;
               end
            end
            LOAD: begin
               addr_d  = ptr_q;
               data_d  = rf_rdata;
               val_d   = 1'b1;
               ptr_d   = ptr_q + ADDR_ONE;
               state_d = SEND;
            end
            SEND: begin
               if (hs) begin
                  if (last_beat) begin
                     // ptr may have wrapped past the top index; it is never
                     // presented, so the wrap is harmless.
                     val_d   = 1'b0;
                     state_d = DONE;
                  end else begin
                     addr_d = ptr_q;
                     data_d = rf_rdata;
                     ptr_d  = ptr_q + ADDR_ONE;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               val_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         hi_q     <= '0;
         out_addr <= '0;
         out_data <= '0;
         out_val  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         hi_q     <= hi_d;
         out_addr <= addr_d;
         out_data <= data_d;
         out_val  <= val_d;
      end
   end

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// ----------------------------------------------------------------------------
// tb_regfile_dump
//
// Bench for regfile_dump paired with a small clocked-write / combinational-read
// register file. Expected beats come from a reference list built from the
// requested range and a shadow copy of the register contents.
// ----------------------------------------------------------------------------
module tb_regfile_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  lo_addr;
   logic [4:0]  hi_addr;
   logic        abort;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        out_val;
   logic        out_rdy;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        busy;
   logic        done;

   // register file: write at the clock edge, read combinationally, R0 = 0
   logic [31:0] rf [32];
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   // shadow of the architectural register values
   logic [31:0] mdl [32];

   int n_chk  = 0;
   int n_fail = 0;

   logic [4:0]  wr_a_g;
   logic [31:0] wr_d_g;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
   end

   assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf[rf_raddr];

   regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .lo_addr  (lo_addr),
      .hi_addr  (hi_addr),
      .abort    (abort),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_addr (out_addr),
      .out_data (out_data),
      .busy     (busy),
      .done     (done)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      mdl[a]  = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_out_val"},  {63'd0, out_val},  64'd0);
      chk({tag, "_out_addr"}, {59'd0, out_addr}, 64'd0);
      chk({tag, "_out_data"}, {32'd0, out_data}, 64'd0);
      chk({tag, "_busy"},     {63'd0, busy},     64'd0);
      chk({tag, "_done"},     {63'd0, done},     64'd0);
      chk({tag, "_rf_raddr"}, {59'd0, rf_raddr}, 64'd0);
   endtask

   // mode: 0 ready always, 1 ready 1,0,0 repeating from the first beat,
   //       2 random ready, 3 ready low only in cycle 2
   // exp_n: expected beat count, or -1 to take it from the reference list
   task automatic run_dump(input logic [4:0] lo, input logic [4:0] hi, input int mode,
                           input int exp_n, input int abort_cyc, input int wr_cyc,
                           input int restart_cyc);
      logic [4:0]  ea [$];
      logic [31:0] ed [$];
      logic [4:0]  ga [$];
      logic [31:0] gd [$];
      int          first_v = -1;
      int          done_n  = 0;
      int          done_c  = -1;
      int          idle_c  = -1;
      int          quiet_bad = 0;
      int          n;
      bit          stalled = 1'b0;
      logic [4:0]  ha = '0;
      logic [31:0] hd = '0;

      @(negedge clk);
      start   = 1'b1;
      lo_addr = lo;
      hi_addr = hi;
      abort   = 1'b0;
      out_rdy = 1'b0;
      for (int c = 1; c <= 200 && idle_c < 0; c++) begin
         @(negedge clk);
         start = (c == restart_cyc);
         if (c == restart_cyc) begin
            lo_addr = 5'd0;
            hi_addr = 5'd31;
         end
         abort = (c == abort_cyc);
         wr_en = (c == wr_cyc);
         if (c == wr_cyc) begin
            wr_addr      = wr_a_g;
            wr_data      = wr_d_g;
            mdl[wr_a_g]  = wr_d_g;
         end
         case (mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ((c + 1) % 3 == 0);
            3:       out_rdy = (c != 2);
            default: out_rdy = 1'($urandom_range(0, 1));
         endcase
         if (!busy) begin
            idle_c = c;
         end else begin
            if (done) begin
               done_n++;
               done_c = c;
            end
            if (out_val) begin
               if (first_v < 0) first_v = c;
               if (stalled) begin
                  chk("stall_addr", {59'd0, out_addr}, {59'd0, ha});
                  chk("stall_data", {32'd0, out_data}, {32'd0, hd});
               end
               if (out_rdy && !abort) begin
                  ga.push_back(out_addr);
                  gd.push_back(out_data);
               end
               stalled = !out_rdy;
               ha = out_addr;
               hd = out_data;
            end else begin
               stalled = 1'b0;
            end
         end
      end
      start   = 1'b0;
      abort   = 1'b0;
      out_rdy = 1'b0;
      wr_en   = 1'b0;
      chk("timeout", {63'd0, (idle_c < 0)}, 64'd0);

      if (lo <= hi) begin
         for (int i = int'(lo); i <= int'(hi); i++) begin
            ea.push_back(5'(i));
            ed.push_back((i == 0) ? 32'd0 : mdl[i]);
         end
      end
      n = (exp_n < 0) ? ea.size() : exp_n;
      chk("beat_count", 64'(ga.size()), 64'(n));
      for (int i = 0; i < ga.size() && i < ea.size(); i++) begin
         chk("beat_addr", {59'd0, ga[i]}, {59'd0, ea[i]});
         chk("beat_data", {32'd0, gd[i]}, {32'd0, ed[i]});
      end
      chk("done_count", 64'(done_n), (abort_cyc > 0) ? 64'd0 : 64'd1);
      if (abort_cyc > 0) chk("abort_idle_cycle", 64'(idle_c), 64'(abort_cyc + 1));
      if (mode == 0 && abort_cyc < 0) begin
         chk("first_val_cycle", 64'(first_v), (n > 0) ? 64'd2 : 64'(-1));
         chk("done_cycle",      64'(done_c),  (n > 0) ? 64'(n + 2) : 64'd1);
         chk("idle_cycle",      64'(idle_c),  (n > 0) ? 64'(n + 3) : 64'd2);
      end
      repeat (3) begin
         @(negedge clk);
         if (busy || out_val || done) quiet_bad++;
      end
      chk("quiet_after", 64'(quiet_bad), 64'd0);
   endtask

   typedef struct {
      logic [4:0] lo;
      logic [4:0] hi;
      int         mode;
      int         exp_n;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{lo: 5'd0,  hi: 5'd31, mode: 0, exp_n: 32};
      tbl[1] = '{lo: 5'd5,  hi: 5'd7,  mode: 1, exp_n: 3};
      tbl[2] = '{lo: 5'd9,  hi: 5'd3,  mode: 0, exp_n: 0};
      tbl[3] = '{lo: 5'd4,  hi: 5'd4,  mode: 0, exp_n: 1};
      tbl[4] = '{lo: 5'd0,  hi: 5'd0,  mode: 0, exp_n: 1};
      tbl[5] = '{lo: 5'd31, hi: 5'd31, mode: 2, exp_n: 1};
      tbl[6] = '{lo: 5'd28, hi: 5'd31, mode: 1, exp_n: 4};
      tbl[7] = '{lo: 5'd10, hi: 5'd20, mode: 2, exp_n: 11};

      rst     = 1'b1;
      start   = 1'b0;
      lo_addr = '0;
      hi_addr = '0;
      abort   = 1'b0;
      out_rdy = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      wr_a_g  = 5'd31;
      wr_d_g  = 32'hDEAD;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("reset");

      for (int i = 0; i < 32; i++) rf_write(5'(i), 32'h100 + 32'(i));

      // table-driven ranges
      for (int i = 0; i < 8; i++)
         run_dump(tbl[i].lo, tbl[i].hi, tbl[i].mode, tbl[i].exp_n, -1, -1, -1);

      // R31 rewritten while beat 30 is stalled: beat 31 must carry the new value
      run_dump(5'd30, 5'd31, 3, -1, -1, 2, -1);
      chk("r31_value", {32'd0, mdl[31]}, 64'h0000_DEAD);
      rf_write(5'd31, 32'h11F);

      // abort in the second SEND cycle, then a full clean dump
      run_dump(5'd0, 5'd31, 0, 1, 3, -1, -1);
      run_dump(5'd0, 5'd31, 0, -1, -1, -1, -1);

      // start while busy is ignored
      run_dump(5'd2, 5'd4, 0, 3, -1, -1, 3);

      // reset in the middle of a dump
      @(negedge clk);
      start   = 1'b1;
      lo_addr = 5'd0;
      hi_addr = 5'd31;
      out_rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_val_before_rst", {63'd0, out_val}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      out_rdy = 1'b0;
      check_reset_vals("mid_reset");
      run_dump(5'd6, 5'd9, 0, 4, -1, -1, -1);

      // randomized ranges and contents
      for (int it = 0; it < 6; it++) begin
         logic [4:0] rlo, rhi;
         for (int k = 0; k < 4; k++) rf_write(5'($urandom_range(0, 31)), $urandom);
         rlo = 5'($urandom_range(0, 31));
         rhi = 5'($urandom_range(0, 31));
         run_dump(rlo, rhi, 2, -1, -1, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_regfile_dump
